apb_gpio_master: RTL and testbench

//  Single-outstanding APB4 requester that drives the gpio block's APB slave port.

---
 rtl/apb_gpio_master_if.sv | 17 +
 rtl/apb_gpio_master.sv | 93 +++++++++
 tb/tb_apb_gpio_master.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_gpio_master_if.sv
// apb_gpio_master_if: APB4 bus between apb_gpio_master (master) and the gpio slave port
interface apb_gpio_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int PADDR_SIZE = 4
);
   logic                    PSEL;
   logic                    PENABLE;
   logic [PADDR_SIZE-1:0]   PADDR;
   logic                    PWRITE;
   logic [DATA_WIDTH-1:0]   PWDATA;
   logic [DATA_WIDTH/8-1:0] PSTRB;
   logic                    PREADY;
   logic [DATA_WIDTH-1:0]   PRDATA;
   logic                    PSLVERR;
   modport master(output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, input PREADY, PRDATA, PSLVERR);
   modport slave(input PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, output PREADY, PRDATA, PSLVERR);
endinterface

// File: rtl/apb_gpio_master.sv
// apb_gpio_master: single-outstanding APB4 requester bridging a valid/ready command/response pair.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_gpio_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int PADDR_SIZE     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [PADDR_SIZE-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_strb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   apb_gpio_master_if.master       apb
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   state_t state;
   if (DATA_WIDTH % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("apb_gpio_master: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
   end
`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
`endif
   always_ff @(posedge PCLK or posedge PRESET)
      if (PRESET) begin
         state       <= IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         apb.PSEL    <= 1'b0;
         apb.PENABLE <= 1'b0;
         apb.PADDR   <= '0;
         apb.PWRITE  <= 1'b0;
         apb.PWDATA  <= '0;
         apb.PSTRB   <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
         cnt         <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               apb.PADDR  <= req_addr;
               apb.PWRITE <= req_write;
               apb.PWDATA <= req_write ? req_wdata : '0;
               apb.PSTRB  <= req_write ? req_strb : '0;
               apb.PSEL   <= 1'b1;
               req_ready  <= 1'b0;
               state      <= SETUP;
            end
            SETUP: begin
               apb.PENABLE <= 1'b1;
               state       <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
               cnt         <= '0;
`endif
            end
            ACCESS: if (apb.PREADY) begin
               rsp_rdata   <= apb.PWRITE ? '0 : apb.PRDATA;
               rsp_err     <= apb.PSLVERR;
               rsp_valid   <= 1'b1;
               apb.PSEL    <= 1'b0;
               apb.PENABLE <= 1'b0;
               state       <= RESP;
            end
`ifdef APB_MASTER_TIMEOUT_EN
            // the edge closing the last permitted wait cycle aborts unless PREADY rescued it above
            else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               cnt         <= cnt + CW'(1);
               rsp_rdata   <= '0;
               rsp_err     <= 1'b1;
               rsp_valid   <= 1'b1;
               apb.PSEL    <= 1'b0;
               apb.PENABLE <= 1'b0;
               state       <= RESP;
            end else
               cnt <= cnt + CW'(1);
`endif
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
endmodule

// File: tb/tb_apb_gpio_master.sv
// tb_apb_gpio_master: randomized self-checking bench with a rule-level expectation model
module tb_apb_gpio_master;
   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        req_valid, req_ready, req_write;
   logic [3:0]  req_addr, req_strb;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   int total = 0, bad = 0;
   logic prev_psel = 1'b0;
   logic ob_acc, ob_psel, ob_pens, ob_pwrite, ob_stable, ob_hold, ob_rrlow, ob_seen, ob_err, ob_idle;
   logic [3:0]  ob_paddr, ob_pstrb;
   logic [31:0] ob_pwdata, ob_rdata;
   int ob_pen, ob_lat;
   apb_gpio_master_if #(.DATA_WIDTH(32), .PADDR_SIZE(4)) apb();
   apb_gpio_master #(.DATA_WIDTH(32), .PADDR_SIZE(4), .TIMEOUT_CYCLES(16)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .apb(apb.master)
   );
   always #5 PCLK = ~PCLK;
   always @(negedge PCLK) begin
      total++;
      if (apb.PENABLE === 1'b1 && prev_psel !== 1'b1) begin bad++; $display("FAIL mon_penable_without_psel got=1 exp=0"); end
      total++;
      if ((apb.PSEL === 1'b1 || apb.PENABLE === 1'b1) && rsp_valid === 1'b1) begin bad++; $display("FAIL mon_psel_with_rsp got=1 exp=0"); end
      prev_psel = apb.PSEL;
   end
   // one complete transfer; records what the DUT showed at each phase, no judging here
   task automatic xfer(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int waits, input logic [31:0] rd, input logic err, input int rdelay);
      int n;
      ob_stable = 1; ob_hold = 1; ob_pen = 0;
      req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin @(negedge PCLK); n++; end
      ob_acc = req_ready;
      @(posedge PCLK);
      @(negedge PCLK);
      req_valid = 0; req_write = ~w; req_addr = ~a; req_wdata = ~d; req_strb = ~s;
      ob_lat = 1;
      ob_psel = apb.PSEL; ob_pens = apb.PENABLE; ob_paddr = apb.PADDR;
      ob_pwrite = apb.PWRITE; ob_pwdata = apb.PWDATA; ob_pstrb = apb.PSTRB;
      for (int i = 0; i < 40; i++) begin
         @(negedge PCLK);
         ob_lat++;
         if (apb.PENABLE !== 1'b1) break;
         ob_pen++;
         if ({apb.PSEL, apb.PADDR, apb.PWRITE, apb.PWDATA, apb.PSTRB} !== {1'b1, ob_paddr, ob_pwrite, ob_pwdata, ob_pstrb}) ob_stable = 0;
         apb.PREADY = (i == waits); apb.PRDATA = rd; apb.PSLVERR = err;
      end
      apb.PREADY = 0; apb.PRDATA = $urandom; apb.PSLVERR = $urandom;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 10) begin @(negedge PCLK); ob_lat++; n++; end
      ob_seen = rsp_valid; ob_rdata = rsp_rdata; ob_err = rsp_err; ob_rrlow = (req_ready === 1'b0);
      for (int i = 0; i < rdelay; i++) begin
         @(negedge PCLK);
         if (rsp_valid !== 1'b1 || rsp_rdata !== ob_rdata || rsp_err !== ob_err) ob_hold = 0;
         if (req_ready !== 1'b0) ob_rrlow = 0;
      end
      rsp_ready = 1;
      @(negedge PCLK);
      rsp_ready = 0;
      ob_idle = (req_ready === 1'b1 && rsp_valid === 1'b0);
   endtask
   task automatic test_reset();
      @(negedge PCLK);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
      total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
      total++; if (apb.PSEL !== 1'b0) begin bad++; $display("FAIL rst_psel got=%b exp=0", apb.PSEL); end
      total++; if (apb.PENABLE !== 1'b0) begin bad++; $display("FAIL rst_penable got=%b exp=0", apb.PENABLE); end
      total++; if (apb.PADDR !== 4'h0) begin bad++; $display("FAIL rst_paddr got=%h exp=0", apb.PADDR); end
      total++; if (apb.PWRITE !== 1'b0) begin bad++; $display("FAIL rst_pwrite got=%b exp=0", apb.PWRITE); end
      total++; if (apb.PWDATA !== 32'h0) begin bad++; $display("FAIL rst_pwdata got=%h exp=0", apb.PWDATA); end
      total++; if (apb.PSTRB !== 4'h0) begin bad++; $display("FAIL rst_pstrb got=%h exp=0", apb.PSTRB); end
      PRESET = 0;
      @(negedge PCLK);
      total++; if (req_ready !== 1'b1 || apb.PSEL !== 1'b0) begin bad++; $display("FAIL rst_release_idle got=%b%b exp=10", req_ready, apb.PSEL); end
   endtask
   task automatic test_write();
      xfer(1'b1, 4'h4, 32'hA5A5_00FF, 4'hF, 0, $urandom, 1'b0, 0);
      total++; if (ob_acc !== 1'b1) begin bad++; $display("FAIL wr_accept got=%b exp=1", ob_acc); end
      total++; if ({ob_psel, ob_pens} !== 2'b10) begin bad++; $display("FAIL wr_setup_sel_en got=%b%b exp=10", ob_psel, ob_pens); end
      total++; if (ob_paddr !== 4'h4) begin bad++; $display("FAIL wr_paddr got=%h exp=4", ob_paddr); end
      total++; if (ob_pwrite !== 1'b1) begin bad++; $display("FAIL wr_pwrite got=%b exp=1", ob_pwrite); end
      total++; if (ob_pwdata !== 32'hA5A5_00FF) begin bad++; $display("FAIL wr_pwdata got=%h exp=a5a500ff", ob_pwdata); end
      total++; if (ob_pstrb !== 4'hF) begin bad++; $display("FAIL wr_pstrb got=%h exp=f", ob_pstrb); end
      total++; if (ob_pen !== 1) begin bad++; $display("FAIL wr_penable_cycles got=%0d exp=1", ob_pen); end
      total++; if (ob_seen !== 1'b1 || ob_lat !== 3) begin bad++; $display("FAIL wr_latency got=%0d/%b exp=3/1", ob_lat, ob_seen); end
      total++; if (ob_rdata !== 32'h0 || ob_err !== 1'b0) begin bad++; $display("FAIL wr_rsp got=%h/%b exp=0/0", ob_rdata, ob_err); end
      total++; if (ob_idle !== 1'b1) begin bad++; $display("FAIL wr_back_idle got=%b exp=1", ob_idle); end
   endtask
   task automatic test_read_wait();
      xfer(1'b0, 4'h0, $urandom | 32'h1, 4'hF, 3, 32'h1234_5678, 1'b0, 0);
      total++; if (ob_pen !== 4) begin bad++; $display("FAIL rd_penable_cycles got=%0d exp=4", ob_pen); end
      total++; if (ob_pwdata !== 32'h0 || ob_pstrb !== 4'h0) begin bad++; $display("FAIL rd_wdata_strb got=%h/%h exp=0/0", ob_pwdata, ob_pstrb); end
      total++; if (ob_pwrite !== 1'b0 || ob_paddr !== 4'h0) begin bad++; $display("FAIL rd_dir_addr got=%b/%h exp=0/0", ob_pwrite, ob_paddr); end
      total++; if (ob_stable !== 1'b1) begin bad++; $display("FAIL rd_access_stable got=%b exp=1", ob_stable); end
      total++; if (ob_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_rdata got=%h exp=12345678", ob_rdata); end
      total++; if (ob_lat !== 6) begin bad++; $display("FAIL rd_latency got=%0d exp=6", ob_lat); end
   endtask
   task automatic test_slverr_hold();
      xfer(1'b1, 4'hC, $urandom, 4'h5, 0, $urandom, 1'b1, 5);
      total++; if (ob_seen !== 1'b1 || ob_err !== 1'b1) begin bad++; $display("FAIL err_flag got=%b/%b exp=1/1", ob_seen, ob_err); end
      total++; if (ob_rdata !== 32'h0) begin bad++; $display("FAIL err_rdata got=%h exp=0", ob_rdata); end
      total++; if (ob_hold !== 1'b1) begin bad++; $display("FAIL err_rsp_hold got=%b exp=1", ob_hold); end
      total++; if (ob_rrlow !== 1'b1) begin bad++; $display("FAIL err_req_ready_low got=%b exp=1", ob_rrlow); end
      total++; if (ob_idle !== 1'b1) begin bad++; $display("FAIL err_back_idle got=%b exp=1", ob_idle); end
   endtask
   task automatic test_reset_mid();
      int n;
      logic quiet;
      req_valid = 1; req_write = 0; req_addr = 4'h8; req_wdata = $urandom; req_strb = 4'hF; apb.PREADY = 0;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin @(negedge PCLK); n++; end
      @(posedge PCLK);
      @(negedge PCLK);
      req_valid = 0;
      @(negedge PCLK);
      @(negedge PCLK);
      total++; if (apb.PENABLE !== 1'b1) begin bad++; $display("FAIL rm_in_access got=%b exp=1", apb.PENABLE); end
      PRESET = 1;
      #1;
      total++; if (apb.PSEL !== 1'b0 || apb.PENABLE !== 1'b0) begin bad++; $display("FAIL rm_apb_drop got=%b%b exp=00", apb.PSEL, apb.PENABLE); end
      @(negedge PCLK);
      PRESET = 0;
      quiet = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge PCLK);
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || apb.PSEL !== 1'b0) quiet = 0;
      end
      total++; if (quiet !== 1'b1) begin bad++; $display("FAIL rm_no_response got=%b exp=1", quiet); end
      xfer(1'b1, 4'h2, $urandom, 4'h3, 0, $urandom, 1'b0, 0);
      total++; if (ob_seen !== 1'b1 || ob_lat !== 3) begin bad++; $display("FAIL rm_next_write_lat got=%0d/%b exp=3/1", ob_lat, ob_seen); end
      total++; if (ob_paddr !== 4'h2 || ob_pstrb !== 4'h3 || ob_err !== 1'b0) begin bad++; $display("FAIL rm_next_write got=%h/%h/%b exp=2/3/0", ob_paddr, ob_pstrb, ob_err); end
   endtask
`ifdef APB_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] rd;
      xfer(1'b0, 4'h5, $urandom, 4'hF, 1000, $urandom, 1'b0, 0);
      total++; if (ob_pen !== 16) begin bad++; $display("FAIL to_abort_cycles got=%0d exp=16", ob_pen); end
      total++; if (ob_seen !== 1'b1 || ob_err !== 1'b1 || ob_rdata !== 32'h0) begin bad++; $display("FAIL to_abort_rsp got=%b/%b/%h exp=1/1/0", ob_seen, ob_err, ob_rdata); end
      rd = $urandom;
      xfer(1'b0, 4'h6, $urandom, 4'hF, 15, rd, 1'b0, 0);
      total++; if (ob_pen !== 16) begin bad++; $display("FAIL to_limit_cycles got=%0d exp=16", ob_pen); end
      total++; if (ob_err !== 1'b0 || ob_rdata !== rd) begin bad++; $display("FAIL to_limit_rsp got=%b/%h exp=0/%h", ob_err, ob_rdata, rd); end
   endtask
`endif
   task automatic test_back_to_back();
      logic [3:0] ca[3];
      int acc[3];
      logic [3:0] sa[$];
      logic [31:0] rq[$];
      int idx;
      logic go;
      idx = 0;
      for (int i = 0; i < 3; i++) begin ca[i] = 4'($urandom_range(0, 4)) + 4'(i * 5); acc[i] = 0; end
      apb.PREADY = 1; rsp_ready = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge PCLK);
         if (apb.PSEL === 1'b1 && apb.PENABLE === 1'b0) sa.push_back(apb.PADDR);
         apb.PRDATA = {28'hC0DE_000, apb.PADDR};
         if (rsp_valid === 1'b1) rq.push_back(rsp_rdata);
         go = 0;
         if (idx < 3) begin req_valid = 1; req_write = 0; req_addr = ca[idx]; go = (req_ready === 1'b1); end
         else req_valid = 0;
         @(posedge PCLK);
         if (go) begin acc[idx] = i; idx++; end
      end
      apb.PREADY = 0; rsp_ready = 0; req_valid = 0;
      total++; if (idx !== 3) begin bad++; $display("FAIL b2b_accepts got=%0d exp=3", idx); end
      total++; if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin bad++; $display("FAIL b2b_spacing got=%0d,%0d exp=4,4", acc[1] - acc[0], acc[2] - acc[1]); end
      total++; if (sa.size() !== 3 || rq.size() !== 3) begin bad++; $display("FAIL b2b_counts got=%0d/%0d exp=3/3", sa.size(), rq.size()); end
      for (int i = 0; i < 3 && i < sa.size() && i < rq.size(); i++) begin
         total++; if (sa[i] !== ca[i]) begin bad++; $display("FAIL b2b_addr%0d got=%h exp=%h", i, sa[i], ca[i]); end
         total++; if (rq[i] !== {28'hC0DE_000, ca[i]}) begin bad++; $display("FAIL b2b_rdata%0d got=%h exp=%h", i, rq[i], {28'hC0DE_000, ca[i]}); end
      end
      @(negedge PCLK);
   endtask
   task automatic test_random();
      logic w, e;
      logic [3:0] a, s;
      logic [31:0] d, rd;
      int wt, rdl;
      for (int i = 0; i < 25; i++) begin
         w = 1'($urandom); a = 4'($urandom); s = 4'($urandom); d = $urandom; rd = $urandom;
         e = ($urandom_range(0, 3) == 0); wt = $urandom_range(0, 3); rdl = $urandom_range(0, 2);
         xfer(w, a, d, s, wt, rd, e, rdl);
         total++; if (ob_acc !== 1'b1 || ob_seen !== 1'b1) begin bad++; $display("FAIL rnd%0d handshake got=%b/%b exp=1/1", i, ob_acc, ob_seen); end
         total++; if ({ob_psel, ob_pens} !== 2'b10) begin bad++; $display("FAIL rnd%0d setup got=%b%b exp=10", i, ob_psel, ob_pens); end
         total++; if (ob_paddr !== a) begin bad++; $display("FAIL rnd%0d paddr got=%h exp=%h", i, ob_paddr, a); end
         total++; if (ob_pwrite !== w) begin bad++; $display("FAIL rnd%0d pwrite got=%b exp=%b", i, ob_pwrite, w); end
         total++; if (ob_pwdata !== (w ? d : 32'h0)) begin bad++; $display("FAIL rnd%0d pwdata got=%h exp=%h", i, ob_pwdata, w ? d : 32'h0); end
         total++; if (ob_pstrb !== (w ? s : 4'h0)) begin bad++; $display("FAIL rnd%0d pstrb got=%h exp=%h", i, ob_pstrb, w ? s : 4'h0); end
         total++; if (ob_pen !== wt + 1) begin bad++; $display("FAIL rnd%0d penable_cycles got=%0d exp=%0d", i, ob_pen, wt + 1); end
         total++; if (ob_lat !== wt + 3) begin bad++; $display("FAIL rnd%0d latency got=%0d exp=%0d", i, ob_lat, wt + 3); end
         total++; if (ob_rdata !== (w ? 32'h0 : rd)) begin bad++; $display("FAIL rnd%0d rdata got=%h exp=%h", i, ob_rdata, w ? 32'h0 : rd); end
         total++; if (ob_err !== e) begin bad++; $display("FAIL rnd%0d err got=%b exp=%b", i, ob_err, e); end
         total++; if (ob_stable !== 1'b1 || ob_hold !== 1'b1) begin bad++; $display("FAIL rnd%0d stable got=%b/%b exp=1/1", i, ob_stable, ob_hold); end
         total++; if (ob_rrlow !== 1'b1 || ob_idle !== 1'b1) begin bad++; $display("FAIL rnd%0d req_ready got=%b/%b exp=1/1", i, ob_rrlow, ob_idle); end
      end
   endtask
   initial begin
      PRESET = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_strb = 0; rsp_ready = 0;
      apb.PREADY = 0; apb.PRDATA = 0; apb.PSLVERR = 0;
      test_reset();
      test_write();
      test_read_wait();
      test_slverr_hold();
      test_reset_mid();
`ifdef APB_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
